// File: rtl/chess_pkg.sv
// Shared chess types: 5-bit cell encoding, request/response enums and the start position.
package chess_pkg;

  localparam int unsigned CELL_W  = 5;
  localparam int unsigned BOARD_N = 8;
  localparam int unsigned IDX_W   = 3;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  localparam logic [2:0] T_NONE   = 3'b000;
  localparam logic [2:0] T_PAWN   = 3'b001;
  localparam logic [2:0] T_KNIGHT = 3'b010;
  localparam logic [2:0] T_BISHOP = 3'b011;
  localparam logic [2:0] T_ROOK   = 3'b100;
  localparam logic [2:0] T_QUEEN  = 3'b101;
  localparam logic [2:0] T_KING   = 3'b110;

  typedef enum logic [1:0] {
    DIR_FWD = 2'b00,
    DIR_DL  = 2'b01,
    DIR_DR  = 2'b10,
    DIR_RSV = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    RSP_OK       = 2'b00,
    RSP_NOT_PAWN = 2'b01,
    RSP_TARGET   = 2'b10,
    RSP_BAD_DIR  = 2'b11
  } rsp_code_e;

  function automatic cell_t mk_cell(input logic [2:0] ptype, input logic black);
    return {ptype, black, 1'b1};
  endfunction

  // White advances toward row 0, black toward row 7; wraps only when off-board.
  function automatic logic [IDX_W-1:0] next_row(input logic [IDX_W-1:0] row, input logic black);
    return black ? row + 3'd1 : row - 3'd1;
  endfunction

  function automatic logic [IDX_W-1:0] next_col(input logic [IDX_W-1:0] col, input dir_e dir);
    case (dir)
      DIR_DL:  return col - 3'd1;
      DIR_DR:  return col + 3'd1;
      default: return col;
    endcase
  endfunction

  function automatic logic [2:0] back_rank(input int unsigned c);
    case (c)
      0, 7:    return T_ROOK;
      1, 6:    return T_KNIGHT;
      2, 5:    return T_BISHOP;
      3:       return T_QUEEN;
      default: return T_KING;
    endcase
  endfunction

  function automatic board_t init_board();
    board_t b;
    b = '0;
    for (int unsigned c = 0; c < BOARD_N; c++) begin
      b[0][3'(c)] = mk_cell(back_rank(c), 1'b1);
      b[1][3'(c)] = mk_cell(T_PAWN, 1'b1);
      b[6][3'(c)] = mk_cell(T_PAWN, 1'b0);
      b[7][3'(c)] = mk_cell(back_rank(c), 1'b0);
    end
    return b;
  endfunction

endpackage

// File: rtl/pawn_target_check.sv
// Combinational legality check of one pawn move against the current board and side to move.
module pawn_target_check
  import chess_pkg::*;
(
  input  board_t           board,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  input  dir_e             dir,
  input  logic             colour,
  output logic             legal,
  output logic [1:0]       code
);

  logic [IDX_W-1:0] w_dst_row;
  logic [IDX_W-1:0] w_dst_col;
  logic             w_own_pawn;
  logic             w_row_edge;
  logic             w_col_edge;
  logic             w_dst_occ;
  logic             w_dst_black;
  rsp_code_e        w_code;

  assign w_dst_row   = next_row(row, colour);
  assign w_dst_col   = next_col(col, dir);
  assign w_own_pawn  = (board[row][col] == mk_cell(T_PAWN, colour));
  assign w_row_edge  = colour ? (row == 3'd7) : (row == 3'd0);
  assign w_col_edge  = ((dir == DIR_DL) && (col == 3'd0)) || ((dir == DIR_DR) && (col == 3'd7));
  assign w_dst_occ   = board[w_dst_row][w_dst_col][0];
  assign w_dst_black = board[w_dst_row][w_dst_col][1];

  // Priority: bad direction, then source ownership, then destination rules.
  always_comb begin
    w_code = RSP_OK;
    if (dir == DIR_RSV) begin
      w_code = RSP_BAD_DIR;
    end else if (!w_own_pawn) begin
      w_code = RSP_NOT_PAWN;
    end else if (w_row_edge || w_col_edge) begin
      w_code = RSP_TARGET;
    end else if (dir == DIR_FWD) begin
      if (w_dst_occ) w_code = RSP_TARGET;
    end else if (!w_dst_occ || (w_dst_black == colour)) begin
      w_code = RSP_TARGET;
    end
  end

  assign code  = w_code;
  assign legal = (w_code == RSP_OK);

endmodule

// File: rtl/pawn_move_commit.sv
// Board owner: validates latched pawn-move requests and commits legal ones.
// Define PAWN_PROMOTE_EN to promote pawns reaching the last row to queens.
module pawn_move_commit
  import chess_pkg::*;
#(
  parameter bit RESP_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_row,
  input  logic [2:0] req_col,
  input  logic [1:0] req_dir,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_code,
  output board_t     board,
  output logic       turn
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP} state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  dir_e             r_dir;
  board_t           r_board;
  logic             r_turn;
  logic             r_req_ready;
  logic             r_rsp_valid;
  rsp_code_e        r_rsp_code;

  logic             w_legal;
  logic [1:0]       w_code;
  logic [IDX_W-1:0] w_dst_row;
  logic [IDX_W-1:0] w_dst_col;
  cell_t            w_moved;

  pawn_target_check u_check (
    .board  (r_board),
    .row    (r_row),
    .col    (r_col),
    .dir    (r_dir),
    .colour (r_turn),
    .legal  (w_legal),
    .code   (w_code)
  );

  assign w_dst_row = next_row(r_row, r_turn);
  assign w_dst_col = next_col(r_col, r_dir);

  // Piece as it lands on the destination square.
  always_comb begin
    w_moved = r_board[r_row][r_col];
`ifdef PAWN_PROMOTE_EN
    if (w_dst_row == (r_turn ? 3'd7 : 3'd0)) w_moved = {T_QUEEN, w_moved[1:0]};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_dir       <= DIR_FWD;
      r_board     <= init_board();
      r_turn      <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_code  <= RSP_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_row       <= req_row;
            r_col       <= req_col;
            r_dir       <= dir_e'(req_dir);
            r_req_ready <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_legal) begin
            r_state <= S_WRITE;
          end else begin
            r_rsp_code  <= rsp_code_e'(w_code);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WRITE: begin
          r_board[w_dst_row][w_dst_col] <= w_moved;
          r_board[r_row][r_col]         <= '0;
          r_turn      <= ~r_turn;
          r_rsp_code  <= RSP_OK;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready || !RESP_HOLD) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_code  = r_rsp_code;
  assign board     = r_board;
  assign turn      = r_turn;

endmodule

// File: tb/tb_pawn_move_commit.sv
// Self-checking bench for pawn_move_commit: directed vector table, reset corner cases, random play.
module tb_pawn_move_commit;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_row;
  logic [2:0]             req_col;
  logic [1:0]             req_dir;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_code;
  logic [7:0][7:0][4:0]   dut_board;
  logic                   turn;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] m_board [8][8];
  logic       m_turn;

`ifdef PAWN_PROMOTE_EN
  localparam logic [4:0] EXP_PROMO = 5'b10101;
`else
  localparam logic [4:0] EXP_PROMO = 5'b00101;
`endif

  typedef struct {
    bit rst;
    int row;
    int col;
    int dir;
    int code;
    int hold;
  } vec_t;

  vec_t vecs[$];

  pawn_move_commit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_dir   (req_dir),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_code  (rsp_code),
    .board     (dut_board),
    .turn      (turn)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    int back[8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m_board[r][c] = 5'b00000;
    for (int c = 0; c < 8; c++) begin
      m_board[0][c] = {3'(back[c]), 2'b11};
      m_board[1][c] = 5'b00111;
      m_board[6][c] = 5'b00101;
      m_board[7][c] = {3'(back[c]), 2'b01};
    end
    m_turn = 1'b0;
  endtask

  function automatic logic [1:0] model_eval(input int r, input int c, input int d);
    int dr, dc, tr, tc;
    logic [4:0] dst;
    if (d == 3) return 2'b11;
    if (m_board[r][c] != {3'b001, m_turn, 1'b1}) return 2'b01;
    dr = m_turn ? 1 : -1;
    dc = (d == 1) ? -1 : ((d == 2) ? 1 : 0);
    tr = r + dr;
    tc = c + dc;
    if (tr < 0 || tr > 7 || tc < 0 || tc > 7) return 2'b10;
    dst = m_board[tr][tc];
    if (d == 0 && dst[0]) return 2'b10;
    if (d != 0 && (!dst[0] || dst[1] == m_turn)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_apply(input int r, input int c, input int d);
    int tr, tc;
    logic [4:0] piece;
    tr = r + (m_turn ? 1 : -1);
    tc = c + ((d == 1) ? -1 : ((d == 2) ? 1 : 0));
    piece = m_board[r][c];
`ifdef PAWN_PROMOTE_EN
    if (tr == 0 || tr == 7) piece[4:2] = 3'b101;
`endif
    m_board[tr][tc] = piece;
    m_board[r][c]   = 5'b00000;
    m_turn          = ~m_turn;
  endtask

  function automatic int board_diff();
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (dut_board[r][c] !== m_board[r][c]) n++;
    return n;
  endfunction

  task automatic check_idle_state(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_turn"}, turn, m_turn);
    chk({tag, "_board"}, board_diff(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full request/response handshake; exp_in < 0 takes the expected code from the model.
  task automatic do_move(input int r, input int c, input int d, input int exp_in, input int hold);
    logic [1:0] exp;
    int lat;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req_ready === 1'b1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("idle_wait", got, 1);
    exp = (exp_in < 0) ? model_eval(r, c, d) : 2'(exp_in);
    req_row = 3'(r); req_col = 3'(c); req_dir = 2'(d);
    req_valid = 1'b1; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    chk("busy_ready", req_ready, 0);
    req_row = 3'($urandom); req_col = 3'($urandom); req_dir = 2'($urandom);
    got = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      got = (rsp_valid === 1'b1);
    end
    req_valid = 1'b0;
    chk("rsp_seen", got, 1);
    chk("latency", lat, (exp == 2'b00) ? 2 : 1);
    chk("rsp_code", rsp_code, exp);
    if (model_eval(r, c, d) == 2'b00) model_apply(r, c, d);
    chk("board", board_diff(), 0);
    chk("turn", turn, m_turn);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold", {rsp_valid, req_ready}, 2'b10);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release", {rsp_valid, req_ready}, 2'b01);
  endtask

  function automatic vec_t mkv(input bit rst, input int r, input int c, input int d,
                               input int code, input int hold);
    vec_t v;
    v.rst = rst; v.row = r; v.col = c; v.dir = d; v.code = code; v.hold = hold;
    return v;
  endfunction

  initial begin
    int pr[$];
    int pc[$];
    int r, c, d, k;

    // Game from reset: forward moves, all error codes, own-colour and empty diagonals, captures.
    vecs.push_back(mkv(0, 6, 4, 0, 0, 0));
    vecs.push_back(mkv(0, 6, 3, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 1, 2, 0));
    vecs.push_back(mkv(0, 1, 4, 2, 2, 0));
    vecs.push_back(mkv(0, 1, 4, 3, 3, 2));
    vecs.push_back(mkv(0, 4, 4, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 4, 0, 0, 0));
    vecs.push_back(mkv(0, 5, 4, 0, 0, 0));
    vecs.push_back(mkv(0, 2, 4, 0, 0, 0));
    vecs.push_back(mkv(0, 4, 4, 0, 2, 0));
    vecs.push_back(mkv(0, 7, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 6, 3, 0, 0, 3));
    vecs.push_back(mkv(0, 1, 2, 0, 0, 0));
    vecs.push_back(mkv(0, 6, 2, 2, 2, 0));
    vecs.push_back(mkv(0, 5, 3, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 7, 0, 0, 0));
    vecs.push_back(mkv(0, 4, 3, 0, 0, 0));
    vecs.push_back(mkv(0, 2, 7, 0, 0, 0));
    vecs.push_back(mkv(0, 3, 3, 2, 2, 0));
    vecs.push_back(mkv(0, 3, 3, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 1, 2, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0));
    // Fresh game: white pawn on column 6 walks up and captures onto row 0.
    vecs.push_back(mkv(1, 6, 6, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 5, 6, 0, 0, 0));
    vecs.push_back(mkv(0, 2, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 4, 6, 0, 0, 0));
    vecs.push_back(mkv(0, 3, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 3, 6, 0, 0, 0));
    vecs.push_back(mkv(0, 4, 0, 0, 0, 0));
    vecs.push_back(mkv(0, 2, 6, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 5, 2, 0, 0));
    vecs.push_back(mkv(0, 1, 2, 2, 2, 0));

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_row = '0; req_col = '0; req_dir = '0;
    model_reset();
    #1;
    chk("async_reset_board", board_diff(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle_state("reset");
    chk("reset_rsp_code", rsp_code, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        apply_reset();
        check_idle_state("vec_reset");
      end
      do_move(vecs[i].row, vecs[i].col, vecs[i].dir, vecs[i].code, vecs[i].hold);
    end
    chk("promo_cell", dut_board[0][6], EXP_PROMO);

    // Reset arriving while the legal move sits in WRITE.
    apply_reset();
    req_row = 3'd6; req_col = 3'd4; req_dir = 2'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("write_pending_board", board_diff(), 0);
    reset = 1'b1;
    #1;
    check_idle_state("midreset");
    @(posedge clk); #1;
    chk("midreset_no_rsp", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_state("after_midreset");

    // Random play, mostly choosing own pawns so games progress.
    for (int it = 0; it < 400; it++) begin
      if (it % 100 == 0) apply_reset();
      pr.delete(); pc.delete();
      for (int rr = 0; rr < 8; rr++)
        for (int cc = 0; cc < 8; cc++)
          if (m_board[rr][cc] == {3'b001, m_turn, 1'b1}) begin
            pr.push_back(rr); pc.push_back(cc);
          end
      if (pr.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = int'($urandom_range(0, 32'(pr.size() - 1)));
        r = pr[k]; c = pc[k];
      end else begin
        r = int'($urandom_range(0, 7)); c = int'($urandom_range(0, 7));
      end
      k = int'($urandom_range(0, 9));
      d = (k < 4) ? 0 : ((k < 7) ? 1 : ((k < 9) ? 2 : 3));
      do_move(r, c, d, -1, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
